br_redirect: RTL



---
 rtl/br_redirect_pkg.sv | 34 +++
 rtl/br_oldest_sel.sv | 40 ++++
 rtl/br_redirect.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/br_redirect_pkg.sv
// br_redirect_pkg: types and helpers shared by the branch-redirect block.
//   br_age      : age of a commit index relative to the ring head (smaller = older)
//   br_report_t : one mispredict report (commit addr, target, short flag, dec bits)
//   br_state_e  : redirect FSM states
// The report struct is sized from the package widths below. The module
// parameters of br_redirect must keep these same values.
package br_redirect_pkg;

    localparam int BR_RV       = 64;
    localparam int BR_BDEC     = 4;
    localparam int BR_NCOMMIT  = 32;
    localparam int BR_LNCOMMIT = 5;

    typedef struct packed {
        logic [BR_LNCOMMIT-1:0] addr;
        logic [BR_RV-2:0]       target;
        logic                   is_short;
        logic [BR_BDEC-2:0]     dec;
    } br_report_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } br_state_e;

    // Modular distance from head; wraps naturally in LNCOMMIT bits.
    function automatic logic [BR_LNCOMMIT-1:0] br_age(
        input logic [BR_LNCOMMIT-1:0] idx,
        input logic [BR_LNCOMMIT-1:0] head
    );
        return idx - head;
    endfunction

endpackage

// File: rtl/br_oldest_sel.sv
// br_oldest_sel: combinational pick of the oldest valid mispredict report.
//   req_valid : per-unit report valid
//   req       : per-unit report
//   head      : commit ring head used as the age origin
//   win_valid : at least one report valid
//   win_idx   : unit index of the winner
//   win_rpt   : winning report
//   win_age   : age of the winning report
// Strict less-than keeps the lowest unit index on an age tie.
module br_oldest_sel
    import br_redirect_pkg::*;
#(
    parameter int NBRANCH = 2,
    parameter int IDXW    = (NBRANCH > 1) ? $clog2(NBRANCH) : 1
) (
    input  logic [NBRANCH-1:0]     req_valid,
    input  br_report_t             req [NBRANCH],
    input  logic [BR_LNCOMMIT-1:0] head,
    output logic                   win_valid,
    output logic [IDXW-1:0]        win_idx,
    output br_report_t             win_rpt,
    output logic [BR_LNCOMMIT-1:0] win_age
);

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_rpt   = req[0];
        win_age   = '1;
        for (int i = 0; i < NBRANCH; i++) begin
            if (req_valid[i] && (!win_valid || (br_age(req[i].addr, head) < win_age))) begin
                win_valid = 1'b1;
                win_idx   = IDXW'(i);
                win_rpt   = req[i];
                win_age   = br_age(req[i].addr, head);
            end
        end
    end

endmodule

// File: rtl/br_redirect.sv
// br_redirect: merges branch-unit mispredicts into one fetch redirect.
//   clk, reset             : clock, synchronous active-high reset
//   br_enable/addr/target/short/dec : per-unit mispredict reports
//   commit_head/tail/full  : commit ring pointers (head==tail with full = full)
//   trap_flush             : cancels any pending redirect, no kill/rewind
//   fetch_redirect_ready   : fetch accepts the redirect
//   fetch_redirect_valid/pc/short/dec : held redirect
//   commit_kill            : one-cycle squash mask of entries younger than winner
//   rewind_valid/tail      : one-cycle rename tail rewind to winner+1
module br_redirect
    import br_redirect_pkg::*;
#(
    parameter int NBRANCH  = 2,
    parameter int RV       = BR_RV,
    parameter int BDEC     = BR_BDEC,
    parameter int NCOMMIT  = BR_NCOMMIT,
    parameter int LNCOMMIT = BR_LNCOMMIT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NBRANCH-1:0]           br_enable,
    input  logic [NBRANCH*LNCOMMIT-1:0]  br_addr,
    input  logic [NBRANCH*(RV-1)-1:0]    br_target,
    input  logic [NBRANCH-1:0]           br_short,
    input  logic [NBRANCH*(BDEC-1)-1:0]  br_dec,
    input  logic [LNCOMMIT-1:0]          commit_head,
    input  logic [LNCOMMIT-1:0]          commit_tail,
    input  logic                         commit_full,
    input  logic                         trap_flush,
    input  logic                         fetch_redirect_ready,
    output logic                         fetch_redirect_valid,
    output logic [RV-2:0]                fetch_redirect_pc,
    output logic                         fetch_redirect_short,
    output logic [BDEC-2:0]              fetch_redirect_dec,
    output logic [NCOMMIT-1:0]           commit_kill,
    output logic                         rewind_valid,
    output logic [LNCOMMIT-1:0]          rewind_tail
);

    localparam int IDXW = (NBRANCH > 1) ? $clog2(NBRANCH) : 1;

    br_report_t rpt [NBRANCH];

    genvar gi;
    generate
        for (gi = 0; gi < NBRANCH; gi++) begin : g_unpack
            assign rpt[gi] = '{addr:     br_addr[gi*LNCOMMIT +: LNCOMMIT],
                               target:   br_target[gi*(RV-1) +: RV-1],
                               is_short: br_short[gi],
                               dec:      br_dec[gi*(BDEC-1) +: BDEC-1]};
        end
    endgenerate

    logic                sel_valid;
    logic [IDXW-1:0]     sel_idx;
    br_report_t          sel_rpt;
    logic [LNCOMMIT-1:0] sel_age;

    br_oldest_sel #(.NBRANCH(NBRANCH), .IDXW(IDXW)) u_sel (
        .req_valid (br_enable),
        .req       (rpt),
        .head      (commit_head),
        .win_valid (sel_valid),
        .win_idx   (sel_idx),
        .win_rpt   (sel_rpt),
        .win_age   (sel_age)
    );

    br_state_e           state_reg, state_next;
    br_report_t          held_reg, held_next;
    logic [NCOMMIT-1:0]  kill_reg, kill_next;
    logic                rewind_valid_reg, rewind_valid_next;
    logic [LNCOMMIT-1:0] rewind_tail_reg, rewind_tail_next;

    // Held entry is re-aged against the live head every cycle, since head
    // may retire forward while the redirect stalls.
    logic [LNCOMMIT-1:0] held_age;
    logic                take;
    assign held_age = br_age(held_reg.addr, commit_head);
    assign take     = sel_valid && ((state_reg == IDLE) || (sel_age < held_age));

    // A full ring has head==tail, so tail's age is forced to NCOMMIT to make
    // every entry younger than the winner killable.
    logic [LNCOMMIT:0] tail_age_ext;
    assign tail_age_ext = commit_full ? (LNCOMMIT+1)'(NCOMMIT)
                                      : {1'b0, br_age(commit_tail, commit_head)};

    logic [NCOMMIT-1:0] kill_mask;
    generate
        for (gi = 0; gi < NCOMMIT; gi++) begin : g_kill
            logic [LNCOMMIT-1:0] idx_age;
            assign idx_age       = br_age(LNCOMMIT'(gi), commit_head);
            assign kill_mask[gi] = (idx_age > sel_age) && ({1'b0, idx_age} < tail_age_ext);
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        held_next         = held_reg;
        kill_next         = '0;
        rewind_valid_next = 1'b0;
        rewind_tail_next  = rewind_tail_reg;
        if (trap_flush) begin
            state_next = IDLE;
        end else if (take) begin
            // An older arrival beats a same-cycle ready handshake.
            state_next        = HOLD;
            held_next         = sel_rpt;
            kill_next         = kill_mask;
            rewind_valid_next = 1'b1;
            rewind_tail_next  = sel_rpt.addr + LNCOMMIT'(1);
        end else if ((state_reg == HOLD) && fetch_redirect_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            held_reg         <= '0;
            kill_reg         <= '0;
            rewind_valid_reg <= 1'b0;
            rewind_tail_reg  <= '0;
        end else begin
            state_reg        <= state_next;
            held_reg         <= held_next;
            kill_reg         <= kill_next;
            rewind_valid_reg <= rewind_valid_next;
            rewind_tail_reg  <= rewind_tail_next;
        end
    end

    assign fetch_redirect_valid = (state_reg == HOLD);
    assign fetch_redirect_pc    = held_reg.target;
    assign fetch_redirect_short = held_reg.is_short;
    assign fetch_redirect_dec   = held_reg.dec;
    assign commit_kill          = kill_reg;
    assign rewind_valid         = rewind_valid_reg;
    assign rewind_tail          = rewind_tail_reg;

    // Two units can never report the same commit entry.
    logic dup_addr;
    always_comb begin
        dup_addr = 1'b0;
        for (int i = 0; i < NBRANCH; i++) begin
            for (int j = i + 1; j < NBRANCH; j++) begin
                if (br_enable[i] && br_enable[j] && (rpt[i].addr == rpt[j].addr)) begin
                    dup_addr = 1'b1;
                end
            end
        end
    end

    a_no_dup_addr: assert property (@(posedge clk) disable iff (reset) !dup_addr);
    a_sel_enabled: assert property (@(posedge clk) disable iff (reset) sel_valid |-> br_enable[sel_idx]);

endmodule
